isolde_instr_encoder: RTL and testbench

- Encodes an ISOLDE opcode plus operand fields into the matching variable-length custom instruction: 1, 2, 3 or 5 words of 32 bits.
- Serializes those words onto a valid/ready stream, one word per handshake.
- It is the encoder counterpart of the ISOLDE opcode decoder. It is used by the instruction-injection/test front end and by the host-side command path that feeds the core fetch stream.

---
 rtl/isolde_instr_encoder.sv | 181 ++++++++++++++++++
 tb/tb_isolde_instr_encoder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/isolde_instr_encoder.sv
// isolde_instr_encoder
//   Encodes an ISOLDE opcode plus operand fields into a 1/2/3/5-word custom
//   instruction and serializes the words onto a valid/ready stream.
// Ports:
//   clk_i, rst_i        clock, asynchronous active-high reset
//   req_*               request handshake, opcode, register fields, extension words
//   instr_*             output word stream with index and first/last markers
//   err_o               one-cycle pulse after a rejected request
//   instr_cnt_o         saturating count of fully emitted instructions
module isolde_instr_encoder #(
   parameter int unsigned CNT_W = 16
) (
   input  logic             clk_i,
   input  logic             rst_i,
   input  logic             req_valid_i,
   output logic             req_ready_o,
   input  logic [5:0]       req_op_i,
   input  logic [4:0]       req_rd_i,
   input  logic [2:0]       req_funct3_i,
   input  logic [4:0]       req_rs1_i,
   input  logic [4:0]       req_rs2_i,
   input  logic [6:0]       req_func7_i,
   input  logic [127:0]     req_ext_i,
   output logic             instr_valid_o,
   input  logic             instr_ready_i,
   output logic [31:0]      instr_word_o,
   output logic [2:0]       instr_idx_o,
   output logic             instr_first_o,
   output logic             instr_last_o,
   output logic             err_o,
   output logic [CNT_W-1:0] instr_cnt_o
);

   typedef enum logic {
      IDLE,
      SEND
   } state_e;

   typedef enum logic [5:0] {
      OP_INVALID      = 6'd0,
      OP_NOP          = 6'd1,
      OP_VLE32_4      = 6'd2,
      OP_GEMM         = 6'd3,
      OP_CONV2D       = 6'd4,
      OP_R_TYPE       = 6'd5,
      OP_REDMULE      = 6'd6,
      OP_REDMULE_GEMM = 6'd7
   } isolde_opcode_e;

   state_e           state_q, state_d;
   logic [2:0]       idx_q, idx_d;
   logic [2:0]       len_q, len_d;
   logic [31:0]      buf_q [5];
   logic [31:0]      buf_d [5];
   logic             ready_q, ready_d;
   logic             valid_q, valid_d;
   logic             err_q, err_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic [6:0]       enc_opc;
   logic [2:0]       enc_f3;
   logic [6:0]       enc_f7;
   logic [2:0]       enc_len;
   logic             enc_ok;
   logic             accept;
   logic             out_hs;
   logic             out_last;

   // Opcode -> word0 fixed fields and instruction length
   always_comb begin
      enc_opc = '0;
      enc_f3  = req_funct3_i;
      enc_f7  = req_func7_i;
      enc_len = 3'd1;
      enc_ok  = 1'b1;
      case (req_op_i)
         OP_VLE32_4: begin
            enc_opc = 7'h7F; enc_f3 = 3'h5; enc_f7 = 7'h03; enc_len = 3'd5;
         end
         OP_REDMULE_GEMM: begin
            enc_opc = 7'h7F; enc_f3 = 3'h5; enc_f7 = 7'h04; enc_len = 3'd5;
         end
         OP_CONV2D: begin
            enc_opc = 7'h7F; enc_f3 = 3'h1; enc_f7 = 7'h00; enc_len = 3'd3;
         end
         OP_GEMM: begin
            enc_opc = 7'h3F; enc_f7 = 7'h07; enc_len = 3'd2;
         end
         OP_R_TYPE: begin
            enc_opc = 7'h0B;
         end
         OP_REDMULE: begin
            enc_opc = 7'h2B;
         end
         default: begin
            enc_ok = 1'b0;
         end
      endcase
   end

   // ready_q is only set while IDLE, so it alone qualifies the accept
   assign accept   = req_valid_i & ready_q;
   assign out_hs   = valid_q & instr_ready_i;
   assign out_last = (idx_q == len_q - 3'd1);

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      len_d   = len_q;
      buf_d   = buf_q;
      cnt_d   = cnt_q;
      err_d   = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (enc_ok) begin
                  buf_d[0] = {enc_f7, req_rs2_i, req_rs1_i, enc_f3, req_rd_i, enc_opc};
                  for (int unsigned k = 1; k < 5; k++) begin
                     buf_d[k] = req_ext_i[32*(k-1) +: 32];
                  end
                  len_d   = enc_len;
                  idx_d   = '0;
                  state_d = SEND;
               end else begin
                  err_d = 1'b1;
               end
            end
         end
         SEND: begin
            if (out_hs) begin
               if (out_last) begin
                  state_d = IDLE;
                  idx_d   = '0;
                  if (cnt_q != '1) begin
                     cnt_d = cnt_q + 1'b1;
                  end
               end else begin
                  idx_d = idx_q + 3'd1;
               end
            end
         end
         default: state_d = IDLE;
      endcase
      ready_d = (state_d == IDLE);
      valid_d = (state_d == SEND);
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= IDLE;
         idx_q   <= '0;
         len_q   <= '0;
         ready_q <= 1'b0;
         valid_q <= 1'b0;
         err_q   <= 1'b0;
         cnt_q   <= '0;
         for (int unsigned k = 0; k < 5; k++) begin
            buf_q[k] <= '0;
         end
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         len_q   <= len_d;
         ready_q <= ready_d;
         valid_q <= valid_d;
         err_q   <= err_d;
         cnt_q   <= cnt_d;
         buf_q   <= buf_d;
      end
   end

   assign req_ready_o   = ready_q;
   assign instr_valid_o = valid_q;
   assign instr_word_o  = valid_q ? buf_q[idx_q] : '0;
   assign instr_idx_o   = valid_q ? idx_q : '0;
   assign instr_first_o = valid_q & (idx_q == 3'd0);
   assign instr_last_o  = valid_q & out_last;
   assign err_o         = err_q;
   assign instr_cnt_o   = cnt_q;

endmodule

// File: tb/tb_isolde_instr_encoder.sv
module tb_isolde_instr_encoder;

   localparam int unsigned CNT_W = 4;

   logic             clk_i = 1'b0;
   logic             rst_i;
   logic             req_valid_i;
   logic             req_ready_o;
   logic [5:0]       req_op_i;
   logic [4:0]       req_rd_i;
   logic [2:0]       req_funct3_i;
   logic [4:0]       req_rs1_i;
   logic [4:0]       req_rs2_i;
   logic [6:0]       req_func7_i;
   logic [127:0]     req_ext_i;
   logic             instr_valid_o;
   logic             instr_ready_i;
   logic [31:0]      instr_word_o;
   logic [2:0]       instr_idx_o;
   logic             instr_first_o;
   logic             instr_last_o;
   logic             err_o;
   logic [CNT_W-1:0] instr_cnt_o;

   int unsigned checks   = 0;
   int unsigned failures = 0;

   isolde_instr_encoder #(.CNT_W(CNT_W)) dut (
      .clk_i         (clk_i),
      .rst_i         (rst_i),
      .req_valid_i   (req_valid_i),
      .req_ready_o   (req_ready_o),
      .req_op_i      (req_op_i),
      .req_rd_i      (req_rd_i),
      .req_funct3_i  (req_funct3_i),
      .req_rs1_i     (req_rs1_i),
      .req_rs2_i     (req_rs2_i),
      .req_func7_i   (req_func7_i),
      .req_ext_i     (req_ext_i),
      .instr_valid_o (instr_valid_o),
      .instr_ready_i (instr_ready_i),
      .instr_word_o  (instr_word_o),
      .instr_idx_o   (instr_idx_o),
      .instr_first_o (instr_first_o),
      .instr_last_o  (instr_last_o),
      .err_o         (err_o),
      .instr_cnt_o   (instr_cnt_o)
   );

   always #5 clk_i = ~clk_i;

   task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge following the accept edge
   task automatic drive_req(input logic [5:0] op, input logic [4:0] rd, input logic [2:0] f3,
                            input logic [4:0] rs1, input logic [4:0] rs2, input logic [6:0] f7,
                            input logic [127:0] ext);
      int unsigned waited = 0;
      req_op_i     = op;
      req_rd_i     = rd;
      req_funct3_i = f3;
      req_rs1_i    = rs1;
      req_rs2_i    = rs2;
      req_func7_i  = f7;
      req_ext_i    = ext;
      req_valid_i  = 1'b1;
      while (!req_ready_o && waited < 20) begin
         @(posedge clk_i); @(negedge clk_i);
         waited++;
      end
      check_eq("req_ready_wait", {63'd0, req_ready_o}, 64'd1);
      @(posedge clk_i); @(negedge clk_i);
      req_valid_i = 1'b0;
   endtask

   // Receives n words, optionally with ready pattern 1,0,0,1 repeating
   task automatic recv(input int unsigned n, input logic [4:0][31:0] w, input bit stall);
      int unsigned k   = 0;
      int unsigned cyc = 0;
      logic rdy;
      while (k < n && cyc < 60) begin
         rdy = stall ? ((cyc % 4) == 0 || (cyc % 4) == 3) : 1'b1;
         instr_ready_i = rdy;
         check_eq("valid",  {63'd0, instr_valid_o}, 64'd1);
         check_eq("word",   {32'd0, instr_word_o}, {32'd0, w[k]});
         check_eq("idx",    {61'd0, instr_idx_o}, 64'(k));
         check_eq("first",  {63'd0, instr_first_o}, {63'd0, (k == 0)});
         check_eq("last",   {63'd0, instr_last_o}, {63'd0, (k == n - 1)});
         @(posedge clk_i); @(negedge clk_i);
         if (rdy) k++;
         cyc++;
      end
      check_eq("recv_done", 64'(k), 64'(n));
      instr_ready_i = 1'b0;
      check_eq("valid_drop", {63'd0, instr_valid_o}, 64'd0);
      check_eq("ready_back", {63'd0, req_ready_o}, 64'd1);
   endtask

   logic [31:0] w0;

   initial begin
      rst_i = 1'b1; req_valid_i = 1'b0; instr_ready_i = 1'b0;
      req_op_i = '0; req_rd_i = '0; req_funct3_i = '0; req_rs1_i = '0;
      req_rs2_i = '0; req_func7_i = '0; req_ext_i = '0;

      #3;
      check_eq("rst_ready", {63'd0, req_ready_o}, 64'd0);
      check_eq("rst_valid", {63'd0, instr_valid_o}, 64'd0);
      check_eq("rst_err",   {63'd0, err_o}, 64'd0);
      check_eq("rst_cnt",   64'(instr_cnt_o), 64'd0);
      check_eq("rst_word",  {32'd0, instr_word_o}, 64'd0);
      @(negedge clk_i); @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      check_eq("rel_ready", {63'd0, req_ready_o}, 64'd1);

      // gemm, ready held high
      drive_req(6'd3, 5'd1, 3'd2, 5'd3, 5'd4, 7'h55, {96'd0, 32'hDEADBEEF});
      recv(2, {32'd0, 32'd0, 32'd0, 32'hDEADBEEF, 32'h0E41A0BF}, 1'b0);
      check_eq("cnt_gemm", 64'(instr_cnt_o), 64'd1);

      // vle32_4 with stalls; funct3 input ignored
      w0 = {7'h03, 5'd7, 5'd6, 3'h5, 5'd2, 7'h7F};
      drive_req(6'd2, 5'd2, 3'd0, 5'd6, 5'd7, 7'h11, {32'd4, 32'd3, 32'd2, 32'd1});
      recv(5, {32'd4, 32'd3, 32'd2, 32'd1, w0}, 1'b1);
      check_eq("cnt_vle", 64'(instr_cnt_o), 64'd2);

      // R_type single word
      drive_req(6'd5, 5'd0, 3'd0, 5'd0, 5'd0, 7'h20, 128'd0);
      recv(1, {128'd0, 32'h4000000B}, 1'b0);
      check_eq("cnt_rtype", 64'(instr_cnt_o), 64'd3);

      // redmule single word
      drive_req(6'd6, 5'd9, 3'd3, 5'd10, 5'd11, 7'h15, 128'hFFFF);
      recv(1, {128'd0, {7'h15, 5'd11, 5'd10, 3'd3, 5'd9, 7'h2B}}, 1'b0);

      // rejected opcodes: nop, invalid, undefined
      for (int i = 0; i < 3; i++) begin
         drive_req((i == 0) ? 6'd1 : (i == 1) ? 6'd0 : 6'd63, 5'd1, 3'd1, 5'd1, 5'd1, 7'd1, 128'd7);
         check_eq("err_pulse",  {63'd0, err_o}, 64'd1);
         check_eq("err_nvalid", {63'd0, instr_valid_o}, 64'd0);
         check_eq("err_ready",  {63'd0, req_ready_o}, 64'd1);
         @(posedge clk_i); @(negedge clk_i);
         check_eq("err_clear",  {63'd0, err_o}, 64'd0);
         check_eq("err_nvalid2", {63'd0, instr_valid_o}, 64'd0);
         check_eq("err_cnt",    64'(instr_cnt_o), 64'd4);
      end

      // conv2d aborted by reset while stalled at idx 1
      drive_req(6'd4, 5'd1, 3'd6, 5'd2, 5'd3, 7'h7F, {32'd0, 32'd0, 32'hBBBB, 32'hAAAA});
      instr_ready_i = 1'b1;
      check_eq("cv_word0", {32'd0, instr_word_o}, {32'd0, 7'h00, 5'd3, 5'd2, 3'h1, 5'd1, 7'h7F});
      @(posedge clk_i); @(negedge clk_i);
      instr_ready_i = 1'b0;
      check_eq("cv_idx1",  {61'd0, instr_idx_o}, 64'd1);
      check_eq("cv_word1", {32'd0, instr_word_o}, 64'hAAAA);
      @(posedge clk_i);
      #2 rst_i = 1'b1;
      #1;
      check_eq("ar_valid", {63'd0, instr_valid_o}, 64'd0);
      check_eq("ar_cnt",   64'(instr_cnt_o), 64'd0);
      check_eq("ar_ready", {63'd0, req_ready_o}, 64'd0);
      @(negedge clk_i);
      rst_i = 1'b0;
      @(posedge clk_i); @(negedge clk_i);
      check_eq("ar_rel_ready", {63'd0, req_ready_o}, 64'd1);
      check_eq("ar_rel_valid", {63'd0, instr_valid_o}, 64'd0);

      drive_req(6'd3, 5'd31, 3'd7, 5'd0, 5'd31, 7'h00, {96'd0, 32'h12345678});
      recv(2, {96'd0, 32'h12345678, 32'h0FF07FBF}, 1'b0);
      check_eq("cnt_after_rst", 64'(instr_cnt_o), 64'd1);

      // saturation at 4'hF
      for (int i = 0; i < 14; i++) begin
         drive_req(6'd5, 5'(i), 3'd0, 5'd0, 5'd0, 7'h00, 128'd0);
         recv(1, {128'd0, {7'h00, 5'd0, 5'd0, 3'd0, 5'(i), 7'h0B}}, 1'b0);
      end
      check_eq("cnt_full", 64'(instr_cnt_o), 64'hF);
      drive_req(6'd5, 5'd3, 3'd0, 5'd0, 5'd0, 7'h00, 128'd0);
      recv(1, {128'd0, 32'h0000018B}, 1'b0);
      check_eq("cnt_sat", 64'(instr_cnt_o), 64'hF);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
